my_fft_n4_stream: RTL and testbench



---
 rtl/my_fft_pkg.sv | 23 ++
 rtl/my_fft_bfly4.sv | 70 +++++++
 rtl/my_fft_n4_stream.sv | 187 ++++++++++++++++++
 tb/tb_my_fft_n4_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/my_fft_pkg.sv
// Shared types and constants for the streaming 4-point DFT engine.
package my_fft_pkg;

    localparam int N_POINTS = 4;
    // Widest internal value: DATA_WIDTH max 48 plus 2 bits of growth.
    localparam int CPLX_W = 50;

    typedef enum logic {
        IN_IDLE,
        IN_COLLECT
    } in_state_t;

    typedef enum logic {
        O_IDLE,
        O_OUT
    } out_state_t;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/my_fft_bfly4.sv
// Combinational 4-point radix-4 butterfly with forward/inverse select.
// MY_FFT_N4_STREAM_SCALE_EN: results are divided by 4 with round-half-up.
module my_fft_bfly4
    import my_fft_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = DATA_WIDTH + 2
) (
    input  logic                                 inverse_i,
    input  logic [N_POINTS-1:0][DATA_WIDTH-1:0]  x_re_i,
    input  logic [N_POINTS-1:0][DATA_WIDTH-1:0]  x_im_i,
    output logic [N_POINTS-1:0][OUT_WIDTH-1:0]   y_re_o,
    output logic [N_POINTS-1:0][OUT_WIDTH-1:0]   y_im_o
);

    function automatic logic signed [CPLX_W-1:0] sext(input logic [DATA_WIDTH-1:0] v);
        return {{(CPLX_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

`ifdef MY_FFT_N4_STREAM_SCALE_EN
    function automatic logic signed [CPLX_W-1:0] round_q2(input logic signed [CPLX_W-1:0] v);
        return (v + CPLX_W'(2)) >>> 2;
    endfunction
`endif

    function automatic logic [OUT_WIDTH-1:0] fit(input logic signed [CPLX_W-1:0] v);
        logic signed [CPLX_W-1:0] t;
`ifdef MY_FFT_N4_STREAM_SCALE_EN
        t = round_q2(v);
`else
        t = v;
`endif
        return t[OUT_WIDTH-1:0];
    endfunction

    cplx_t x [N_POINTS];
    cplx_t y [N_POINTS];
    cplx_t s02, d02, s13, d13, fwd1, fwd3;

    always_comb begin
        for (int i = 0; i < N_POINTS; i++) begin
            x[i].re = sext(x_re_i[i]);
            x[i].im = sext(x_im_i[i]);
        end
        s02.re = x[0].re + x[2].re;
        s02.im = x[0].im + x[2].im;
        d02.re = x[0].re - x[2].re;
        d02.im = x[0].im - x[2].im;
        s13.re = x[1].re + x[3].re;
        s13.im = x[1].im + x[3].im;
        d13.re = x[1].re - x[3].re;
        d13.im = x[1].im - x[3].im;
        // Forward X1 = d02 - j*d13, X3 = d02 + j*d13; inverse swaps them.
        fwd1.re = d02.re + d13.im;
        fwd1.im = d02.im - d13.re;
        fwd3.re = d02.re - d13.im;
        fwd3.im = d02.im + d13.re;
        y[0].re = s02.re + s13.re;
        y[0].im = s02.im + s13.im;
        y[2].re = s02.re - s13.re;
        y[2].im = s02.im - s13.im;
        y[1]    = inverse_i ? fwd3 : fwd1;
        y[3]    = inverse_i ? fwd1 : fwd3;
        for (int i = 0; i < N_POINTS; i++) begin
            y_re_o[i] = fit(y[i].re);
            y_im_o[i] = fit(y[i].im);
        end
    end

endmodule

// File: rtl/my_fft_n4_stream.sv
// Streaming 4-point DFT: frame collection, ping-pong result banks, X0..X3 sequencer.
// MY_FFT_N4_STREAM_SCALE_EN enables 1/4 scaling inside the butterfly.
module my_fft_n4_stream
    import my_fft_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int OUT_WIDTH  = DATA_WIDTH + 2
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  data_in_valid_i,
    input  logic                  data_in_flag_i,
    input  logic                  inverse_i,
    input  logic [DATA_WIDTH-1:0] xn_real_i,
    input  logic [DATA_WIDTH-1:0] xn_imag_i,
    output logic                  data_out_valid_o,
    output logic                  data_out_flag_o,
    output logic [OUT_WIDTH-1:0]  xk_real_o,
    output logic [OUT_WIDTH-1:0]  xk_imag_o,
    output logic                  frame_err_o
);

    in_state_t in_state_q, in_state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       inv_q, inv_d;
    logic       done_q, done_d;
    logic       in_err;
    logic [N_POINTS-1:0][DATA_WIDTH-1:0] smp_re_q, smp_re_d, smp_im_q, smp_im_d;

    logic [1:0][N_POINTS-1:0][OUT_WIDTH-1:0] bank_re_q, bank_re_d, bank_im_q, bank_im_d;
    logic [1:0] full_q, full_d;
    logic       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic       bank_err;

    out_state_t out_state_q, out_state_d;
    logic [1:0] k_q, k_d;
    logic       vld_q, vld_d, flg_q, flg_d, err_q, err_d;
    logic [OUT_WIDTH-1:0] re_q, re_d, im_q, im_d;

    logic [N_POINTS-1:0][OUT_WIDTH-1:0] y_re, y_im;

    my_fft_bfly4 #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_bfly (
        .inverse_i  (inv_q),
        .x_re_i     (smp_re_q),
        .x_im_i     (smp_im_q),
        .y_re_o     (y_re),
        .y_im_o     (y_im)
    );

    // Input collection: a flag always (re)starts a frame at x0.
    always_comb begin
        in_state_d = in_state_q;
        cnt_d      = cnt_q;
        inv_d      = inv_q;
        done_d     = 1'b0;
        in_err     = 1'b0;
        smp_re_d   = smp_re_q;
        smp_im_d   = smp_im_q;
        if (data_in_valid_i) begin
            if (data_in_flag_i) begin
                in_err      = (in_state_q == IN_COLLECT);
                smp_re_d[0] = xn_real_i;
                smp_im_d[0] = xn_imag_i;
                inv_d       = inverse_i;
                in_state_d  = IN_COLLECT;
                cnt_d       = 2'd1;
            end else if (in_state_q == IN_IDLE) begin
                in_err = 1'b1;
            end else begin
                smp_re_d[cnt_q] = xn_real_i;
                smp_im_d[cnt_q] = xn_imag_i;
                if (cnt_q == 2'd3) begin
                    in_state_d = IN_IDLE;
                    cnt_d      = 2'd0;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end
    end

    // Output sequencer and bank fill; a finished bank is released after its X3.
    always_comb begin
        out_state_d = out_state_q;
        k_d         = k_q;
        vld_d       = 1'b0;
        flg_d       = 1'b0;
        re_d        = re_q;
        im_d        = im_q;
        full_d      = full_q;
        rd_sel_d    = rd_sel_q;
        wr_sel_d    = wr_sel_q;
        bank_re_d   = bank_re_q;
        bank_im_d   = bank_im_q;
        bank_err    = 1'b0;
        case (out_state_q)
            O_IDLE: begin
                if (full_q[rd_sel_q]) begin
                    vld_d       = 1'b1;
                    flg_d       = 1'b1;
                    re_d        = bank_re_q[rd_sel_q][0];
                    im_d        = bank_im_q[rd_sel_q][0];
                    out_state_d = O_OUT;
                    k_d         = 2'd1;
                end
            end
            O_OUT: begin
                vld_d = 1'b1;
                re_d  = bank_re_q[rd_sel_q][k_q];
                im_d  = bank_im_q[rd_sel_q][k_q];
                if (k_q == 2'd3) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = ~rd_sel_q;
                    out_state_d      = O_IDLE;
                    k_d              = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: out_state_d = O_IDLE;
        endcase
        if (done_q) begin
            if (!full_q[wr_sel_q]) begin
                bank_re_d[wr_sel_q] = y_re;
                bank_im_d[wr_sel_q] = y_im;
                full_d[wr_sel_q]    = 1'b1;
                wr_sel_d            = ~wr_sel_q;
            end else begin
                bank_err = 1'b1;
            end
        end
        err_d = in_err | bank_err;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            in_state_q  <= IN_IDLE;
            cnt_q       <= 2'd0;
            inv_q       <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 2'b00;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            out_state_q <= O_IDLE;
            k_q         <= 2'd0;
            vld_q       <= 1'b0;
            flg_q       <= 1'b0;
            err_q       <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
        end else begin
            in_state_q  <= in_state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            done_q      <= done_d;
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            out_state_q <= out_state_d;
            k_q         <= k_d;
            vld_q       <= vld_d;
            flg_q       <= flg_d;
            err_q       <= err_d;
            re_q        <= re_d;
            im_q        <= im_d;
        end
    end

    // Sample and bank storage are qualified by the control state, so no reset.
    always_ff @(posedge sys_clk_i) begin
        smp_re_q  <= smp_re_d;
        smp_im_q  <= smp_im_d;
        bank_re_q <= bank_re_d;
        bank_im_q <= bank_im_d;
    end

    assign data_out_valid_o = vld_q;
    assign data_out_flag_o  = flg_q;
    assign xk_real_o        = re_q;
    assign xk_imag_o        = im_q;
    assign frame_err_o      = err_q;

endmodule

// File: tb/tb_my_fft_n4_stream.sv
// Directed bench for my_fft_n4_stream at DATA_WIDTH=8.
module tb_my_fft_n4_stream;

    localparam int DW = 8;
    localparam int OW = DW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          vin, fin, inv;
    logic [DW-1:0] xr, xi;
    logic          vout, fout, ferr;
    logic [OW-1:0] kr, ki;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int err_cnt = 0;
    int x3c     = 0;

    typedef struct {
        int   c;
        logic f;
        int   re;
        int   im;
    } obs_t;
    obs_t oq[$];

    my_fft_n4_stream #(.DATA_WIDTH(DW)) dut (
        .sys_clk_i        (clk),
        .sys_rst_i        (rst),
        .data_in_valid_i  (vin),
        .data_in_flag_i   (fin),
        .inverse_i        (inv),
        .xn_real_i        (xr),
        .xn_imag_i        (xi),
        .data_out_valid_o (vout),
        .data_out_flag_o  (fout),
        .xk_real_o        (kr),
        .xk_imag_o        (ki),
        .frame_err_o      (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vout) oq.push_back('{cyc, fout, int'($signed(kr)), int'($signed(ki))});
        if (ferr) err_cnt = err_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scl(input int v);
`ifdef MY_FFT_N4_STREAM_SCALE_EN
        return (v + 2) >>> 2;
`else
        return v;
`endif
    endfunction

    task automatic drive(input logic v, input logic f, input logic i, input int re, input int im);
        vin = v;
        fin = f;
        inv = i;
        xr  = DW'(re);
        xi  = DW'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        fin = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic i, input int r0, input int r1, input int r2, input int r3,
                         input int im_all, input int gap);
        int r[4];
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k == 0, i, r[k], im_all);
            if (k == 3) x3c = cyc;
            else if (gap != 0) idle(1);
        end
        vin = 1'b0;
        fin = 1'b0;
    endtask

    task automatic wait_outs(input string tag, input int n);
        int t = 0;
        while (oq.size() < n && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_val({tag, "_avail"}, int'(oq.size() >= n), 1);
    endtask

    // Pops one frame and checks values (unscaled references), flags and spacing.
    task automatic chk_frame(input string tag, input int lat_ref,
                             input int r0, input int i0, input int r1, input int i1,
                             input int r2, input int i2, input int r3, input int i3);
        int   er[4];
        int   ei[4];
        obs_t o[4];
        er[0] = r0; er[1] = r1; er[2] = r2; er[3] = r3;
        ei[0] = i0; ei[1] = i1; ei[2] = i2; ei[3] = i3;
        wait_outs(tag, 4);
        if (oq.size() >= 4) begin
            for (int k = 0; k < 4; k++) o[k] = oq.pop_front();
            if (lat_ref >= 0) check_val({tag, "_lat"}, o[0].c - lat_ref, 2);
            for (int k = 0; k < 4; k++) begin
                check_val($sformatf("%s_X%0d_re", tag, k), o[k].re, scl(er[k]));
                check_val($sformatf("%s_X%0d_im", tag, k), o[k].im, scl(ei[k]));
                check_val($sformatf("%s_X%0d_flag", tag, k), int'(o[k].f), int'(k == 0));
                check_val($sformatf("%s_X%0d_gap", tag, k), o[k].c - o[0].c, k);
            end
        end
    endtask

    initial begin
        int e0;
        int x3a;
        rst = 1'b1;
        vin = 1'b0; fin = 1'b0; inv = 1'b0; xr = '0; xi = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", int'(vout), 0);
        check_val("rst_flag", int'(fout), 0);
        check_val("rst_re", int'(kr), 0);
        check_val("rst_im", int'(ki), 0);
        check_val("rst_err", int'(ferr), 0);
        rst = 1'b0;
        idle(2);

        oq.delete();
        frame(1'b0, 1, 0, 0, 0, 0, 0);
        chk_frame("imp", x3c, 1, 0, 1, 0, 1, 0, 1, 0);
        idle(3);

        frame(1'b0, 1, 2, 3, 4, 0, 0);
        chk_frame("fwd", x3c, 10, 0, -2, 2, -2, 0, -2, -2);
        idle(3);

        frame(1'b1, 1, 2, 3, 4, 0, 0);
        chk_frame("inv", x3c, 10, 0, -2, -2, -2, 0, -2, 2);
        idle(3);

        frame(1'b0, -128, -128, -128, -128, -128, 0);
        chk_frame("min", x3c, -512, -512, 0, 0, 0, 0, 0, 0);
        idle(3);

        frame(1'b0, 127, 127, 127, 127, 127, 0);
        chk_frame("max", x3c, 508, 508, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Three frames with valid held high for 12 cycles.
        oq.delete();
        frame(1'b0, 1, 2, 3, 4, 0, 0);
        x3a = x3c;
        frame(1'b0, 1, 0, 0, 0, 0, 0);
        frame(1'b1, 1, 2, 3, 4, 0, 0);
        wait_outs("b2b", 12);
        if (oq.size() >= 12) begin
            for (int k = 0; k < 12; k++) begin
                check_val($sformatf("b2b_cyc%0d", k), oq[k].c - oq[0].c, k);
                check_val($sformatf("b2b_flag%0d", k), int'(oq[k].f), int'(k % 4 == 0));
            end
        end
        chk_frame("b2b_f0", x3a, 10, 0, -2, 2, -2, 0, -2, -2);
        chk_frame("b2b_f1", -1, 1, 0, 1, 0, 1, 0, 1, 0);
        chk_frame("b2b_f2", -1, 10, 0, -2, -2, -2, 0, -2, 2);
        idle(3);

        frame(1'b0, 1, 2, 3, 4, 0, 1);
        chk_frame("gap", x3c, 10, 0, -2, 2, -2, 0, -2, -2);
        idle(3);

        // Truncated frame: flag arrives after two samples.
        oq.delete();
        e0 = err_cnt;
        drive(1'b1, 1'b1, 1'b0, 5, 3);
        drive(1'b1, 1'b0, 1'b0, 6, 3);
        frame(1'b0, 1, 2, 3, 4, 0, 0);
        chk_frame("trunc", x3c, 10, 0, -2, 2, -2, 0, -2, -2);
        idle(8);
        check_val("trunc_err", err_cnt - e0, 1);
        check_val("trunc_extra", oq.size(), 0);

        // Unflagged sample while idle.
        e0 = err_cnt;
        drive(1'b1, 1'b0, 1'b0, 7, 7);
        idle(10);
        check_val("drop_err", err_cnt - e0, 1);
        check_val("drop_out", oq.size(), 0);

        // Reset while X1 is on the outputs.
        oq.delete();
        frame(1'b0, 1, 2, 3, 4, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rstx1_valid_pre", int'(vout), 1);
        check_val("rstx1_re_pre", int'($signed(kr)), scl(-2));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rstx1_valid", int'(vout), 0);
        check_val("rstx1_flag", int'(fout), 0);
        rst = 1'b0;
        idle(8);
        check_val("rstx1_quiet", int'(vout), 0);
        oq.delete();
        frame(1'b0, 1, 2, 3, 4, 0, 0);
        chk_frame("after_rst", x3c, 10, 0, -2, 2, -2, 0, -2, -2);
        idle(8);
        check_val("after_rst_extra", oq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
